// File: rtl/comp_arb_pkg.sv
// Shared types and defaults for the shared comparator arbiter.
// Imported by the picker, the comparator wrapper and the top.
package comp_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 8;
    localparam int ID_W      = 2;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/eight_bit_comp.sv
// Combinational 8-bit magnitude comparator: exactly one of g/q/l is high.
module eight_bit_comp (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       g,
    output logic       q,
    output logic       l
);

    assign g = (a > b);
    assign q = (a == b);
    assign l = (a < b);

endmodule

// File: rtl/rr_picker.sv
// Round-robin winner selection: first set request at or after ptr,
// searching upward and wrapping modulo N_REQ.
module rr_picker
    import comp_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  idx,
    output logic [N_REQ-1:0] onehot,
    output logic             any
);

    logic [ID_W-1:0] cand;

    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    always_comb begin
        idx    = '0;
        onehot = '0;
        any    = 1'b0;
        cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ID_W'((int'(ptr) + i) % N_REQ);
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_comp_arbiter.sv
// Shares one eight_bit_comp among up to four requesters: round-robin grant,
// operand capture, registered compare result over a valid/ready handshake.
module shared_comp_arbiter
    import comp_arb_pkg::*;
#(
    parameter int          N_REQ         = N_REQ_DEF,
    parameter int          W             = W_DEF,
    parameter logic [15:0] DONE_CNT_INIT = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_g,
    output logic               rsp_eq,
    output logic               rsp_l,
    output logic               busy,
    output logic [15:0]        done_cnt
);

    state_t state_q, state_d;

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  ptr_next;
    logic [N_REQ-1:0] gnt_q;
    logic [W-1:0]     op_a, op_b;

    logic [ID_W-1:0]  win_idx;
    logic [N_REQ-1:0] win_onehot;
    logic             win_any;
    logic             cmp_g, cmp_q, cmp_l;
    logic             handshake;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req    (req),
        .ptr    (ptr),
        .idx    (win_idx),
        .onehot (win_onehot),
        .any    (win_any)
    );

    // The single comparator only ever sees the captured operands.
    eight_bit_comp u_comp (
        .a (op_a),
        .b (op_b),
        .g (cmp_g),
        .q (cmp_q),
        .l (cmp_l)
    );

    assign handshake = (state_q == RESP) && rsp_valid && rsp_ready;
    assign ptr_next  = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_any) state_d = CMP;
            CMP:     state_d = RESP;
            RESP:    if (handshake) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            id_q      <= '0;
            gnt_q     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_g     <= 1'b0;
            rsp_eq    <= 1'b0;
            rsp_l     <= 1'b0;
            done_cnt  <= DONE_CNT_INIT;
        end else begin
            gnt_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_any) begin
                        op_a  <= a_in[int'(win_idx) * W +: W];
                        op_b  <= b_in[int'(win_idx) * W +: W];
                        id_q  <= win_idx;
                        gnt_q <= win_onehot;
                    end
                end
                CMP: begin
                    rsp_g     <= cmp_g;
                    rsp_eq    <= cmp_q;
                    rsp_l     <= cmp_l;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (handshake) begin
                        rsp_valid <= 1'b0;
                        ptr       <= ptr_next;
                        if (done_cnt != CNT_MAX) begin
                            done_cnt <= done_cnt + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_shared_comp_arbiter.sv
// Self-checking bench for shared_comp_arbiter: transaction-level reference
// model feeding a scoreboard, directed scenarios plus randomized traffic.
`timescale 1ns/1ps
module tb_shared_comp_arbiter;
    import comp_arb_pkg::*;

    localparam int          N        = N_REQ_DEF;
    localparam int          W        = W_DEF;
    localparam logic [15:0] SAT_INIT = 16'hFFF0;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in, b_in;
    logic           rsp_ready;

    logic [N-1:0]   gnt;
    logic           rsp_valid, rsp_g, rsp_eq, rsp_l, busy;
    logic [1:0]     rsp_id;
    logic [15:0]    done_cnt;

    logic [N-1:0]   s_gnt;
    logic           s_valid, s_g, s_eq, s_l, s_busy;
    logic [1:0]     s_id;
    logic [15:0]    s_done;

    always #5 clk = ~clk;

    shared_comp_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_g(rsp_g), .rsp_eq(rsp_eq), .rsp_l(rsp_l), .busy(busy), .done_cnt(done_cnt)
    );

    // Second instance starts its counter near the top to reach saturation quickly.
    shared_comp_arbiter #(.DONE_CNT_INIT(SAT_INIT)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(s_gnt), .rsp_valid(s_valid), .rsp_ready(rsp_ready), .rsp_id(s_id),
        .rsp_g(s_g), .rsp_eq(s_eq), .rsp_l(s_l), .busy(s_busy), .done_cnt(s_done)
    );

    typedef struct {
        int id;
        bit g;
        bit eq;
        bit l;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state (transaction level).
    int cyc = 0;
    int m_ptr = 0;
    int m_done = 0;
    int m_id = 0;
    int m_gnt_cyc = 0;
    int m_rsp_cyc = 0;
    bit m_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"},      32'(gnt), 0);
        check({tag, "_valid"},    32'(rsp_valid), 0);
        check({tag, "_id"},       32'(rsp_id), 0);
        check({tag, "_gql"},      32'({rsp_g, rsp_eq, rsp_l}), 0);
        check({tag, "_busy"},     32'(busy), 0);
        check({tag, "_done"},     32'(done_cnt), 0);
        check({tag, "_sat_done"}, 32'(s_done), 32'(SAT_INIT));
    endtask

    // Called at posedge+1; asserts reset mid-cycle, checks, releases after next edge.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_zero(tag);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input string name);
        int k = 0;
        tick;
        while (gnt == '0 && k < 20) begin
            tick;
            k++;
        end
        check({name, "_gnt_seen"}, 32'(gnt != '0), 1);
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Model: predicts gnt/valid/busy/done_cnt per cycle and pushes expected results.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 1'b0;
                m_ptr  = 0;
                m_done = 0;
                exp_q.delete();
            end else begin
                logic [N-1:0] exp_gnt;
                bit           exp_valid;
                cyc++;
                exp_gnt   = (m_busy && cyc == m_gnt_cyc) ? N'(1 << m_id) : '0;
                exp_valid = m_busy && (cyc >= m_rsp_cyc);
                check("gnt",      32'(gnt), 32'(exp_gnt));
                check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
                check("busy",     32'(busy), 32'(m_busy));
                check("done_cnt", 32'(done_cnt), 32'(m_done));
                if (exp_valid && rsp_ready) begin
                    m_ptr  = (m_id + 1) % N;
                    m_done = (m_done < 65535) ? m_done + 1 : 65535;
                    m_busy = 1'b0;
                end else if (!m_busy && req != '0) begin
                    logic [7:0] a, b;
                    exp_t e;
                    m_id      = pick(req, m_ptr);
                    m_gnt_cyc = cyc + 1;
                    m_rsp_cyc = cyc + 2;
                    m_busy    = 1'b1;
                    a         = a_in[m_id*W +: W];
                    b         = b_in[m_id*W +: W];
                    e.id = m_id;
                    e.g  = (a > b);
                    e.eq = (a == b);
                    e.l  = (a < b);
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each new response, checks stability while held.
    initial begin
        bit   pv = 1'b0;
        bit   pr = 1'b0;
        exp_t held;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                pr = 1'b0;
            end else begin
                if (rsp_valid) begin
                    check("rsp_onehot", 32'($countones({rsp_g, rsp_eq, rsp_l})), 1);
                    if (!(pv && !pr)) begin
                        check("sb_has_entry", 32'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("rsp_id", 32'(rsp_id), 32'(e.id));
                            check("rsp_gql", 32'({rsp_g, rsp_eq, rsp_l}), 32'({e.g, e.eq, e.l}));
                        end
                    end else begin
                        check("hold_id", 32'(rsp_id), 32'(held.id));
                        check("hold_gql", 32'({rsp_g, rsp_eq, rsp_l}), 32'({held.g, held.eq, held.l}));
                    end
                    held.id = int'(rsp_id);
                    held.g  = rsp_g;
                    held.eq = rsp_eq;
                    held.l  = rsp_l;
                end
                pv = rsp_valid;
                pr = rsp_ready;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int exp_sat;

        rst_n     = 1'b0;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        rsp_ready = 1'b0;
        tick;
        do_reset("reset");

        // Single request, 0x48 vs 0x18.
        set_op(0, 8'h48, 8'h18);
        req       = 4'b0001;
        rsp_ready = 1'b1;
        tick;
        check("single_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick;
        check("single_valid", 32'(rsp_valid), 1);
        check("single_id", 32'(rsp_id), 0);
        check("single_g", 32'(rsp_g), 1);
        tick;
        check("single_done", 32'(done_cnt), 1);

        // Round-robin with all four requesting continuously.
        do_reset("rst_rr");
        set_op(0, 8'h10, 8'h20);
        set_op(1, 8'h5A, 8'h3C);
        set_op(2, 8'h18, 8'h18);
        set_op(3, 8'h00, 8'h01);
        req       = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 60 && order.size() < 5; k++) begin
            tick;
            if (gnt != '0) order.push_back(oh2idx(gnt));
        end
        check("rr_count", 32'(order.size()), 5);
        for (int k = 0; k < 5 && k < order.size(); k++) begin
            check($sformatf("rr_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
        end
        req = '0;
        repeat (4) tick;

        // Backpressure: response held, no grant while requester 1 waits.
        set_op(0, 8'h33, 8'h77);
        rsp_ready = 1'b0;
        req       = 4'b0001;
        wait_gnt("bp_first");
        req = 4'b0010;
        set_op(1, 8'hC0, 8'h0C);
        tick;
        check("bp_valid", 32'(rsp_valid), 1);
        for (int k = 0; k < 5; k++) begin
            tick;
            check("bp_no_gnt", 32'(gnt), 0);
        end
        rsp_ready = 1'b1;
        tick;
        tick;
        check("bp_gnt1", 32'(gnt), 32'h2);
        req = '0;
        repeat (3) tick;

        // Operand change in the CMP cycle must not affect the result.
        set_op(0, 8'h80, 8'h00);
        req = 4'b0001;
        wait_gnt("opchg");
        set_op(0, 8'h00, 8'h00);
        req = '0;
        tick;
        check("opchg_g", 32'(rsp_g), 1);
        tick;

        // Reset while a response is pending.
        set_op(0, 8'h11, 8'h22);
        rsp_ready = 1'b0;
        req       = 4'b0001;
        wait_gnt("rstmid");
        req = '0;
        tick;
        check("rstmid_valid", 32'(rsp_valid), 1);
        do_reset("rst_mid");
        set_op(1, 8'h01, 8'h02);
        set_op(3, 8'hFE, 8'hFD);
        req       = 4'b1010;
        rsp_ready = 1'b1;
        tick;
        check("rstmid_gnt1", 32'(gnt), 32'h2);
        req = 4'b1000;
        wait_gnt("rstmid_second");
        check("rstmid_gnt3", 32'(gnt), 32'h8);
        req = '0;
        repeat (3) tick;

        // Boundary: 0xFF vs 0xFF.
        set_op(2, 8'hFF, 8'hFF);
        req = 4'b0100;
        wait_gnt("ff");
        req = '0;
        tick;
        check("ff_eq", 32'(rsp_eq), 1);
        repeat (2) tick;

        // Randomized traffic: requests, withdrawals, random backpressure.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) req[i] = 1'b0;
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    logic [7:0] a, b;
                    a = 8'($urandom);
                    b = 8'($urandom);
                    case ($urandom_range(0, 5))
                        0: b = a;
                        1: begin a = 8'hFF; b = 8'hFF; end
                        2: a = 8'h00;
                        3: b = 8'hFF;
                        default: ;
                    endcase
                    set_op(i, a, b);
                    req[i] = 1'b1;
                end else if (req[i] && !gnt[i] && $urandom_range(0, 63) == 0) begin
                    req[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            tick;
        end

        req       = '0;
        rsp_ready = 1'b1;
        repeat (10) tick;
        check("sb_drained", 32'(exp_q.size()), 0);
        exp_sat = int'(SAT_INIT) + m_done;
        if (exp_sat > 65535) exp_sat = 65535;
        check("sat_done", 32'(s_done), 32'(exp_sat));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
